compl1_serial_dec: RTL and testbench

//  Bit-serial decoder for WIDTH-bit ones'-complement words, the receive-side

---
 rtl/compl1_serial_dec_if.sv | 25 ++
 rtl/compl1_serial_dec.sv | 99 +++++++++
 tb/tb_compl1_serial_dec.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/compl1_serial_dec_if.sv
// Serial-link side and parallel-result side signals of the ones'-complement serial decoder.
interface compl1_serial_dec_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             cpl;
  logic             bit_in;
  logic             bit_valid;
  logic             ready;
  logic             busy;
  logic             sign;
  logic [WIDTH-2:0] mag;
  logic             neg_zero;
  logic             out_valid;

  modport master (
    output start, cpl, bit_in, bit_valid,
    input  ready, busy, sign, mag, neg_zero, out_valid
  );

  modport slave (
    input  start, cpl, bit_in, bit_valid,
    output ready, busy, sign, mag, neg_zero, out_valid
  );
endinterface

// File: rtl/compl1_serial_dec.sv
// Bit-serial ones'-complement decoder: takes one WIDTH-bit word MSB-first and
// presents it as sign + magnitude, optionally undoing the complement.
module compl1_serial_dec #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               reset,
  compl1_serial_dec_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SIGN, S_MAG, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cpl_r_q, cpl_r_d;
  logic             sign_r_q, sign_r_d;
  logic [WIDTH-2:0] shift_q, shift_d;
  logic             sign_q, sign_d;
  logic [WIDTH-2:0] mag_q, mag_d;
  logic             nz_q, nz_d;

  function automatic logic dec_bit(input logic b, input logic s, input logic c);
    return b ^ (s & c);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cpl_r_q  <= 1'b0;
      sign_r_q <= 1'b0;
      shift_q  <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      nz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cpl_r_q  <= cpl_r_d;
      sign_r_q <= sign_r_d;
      shift_q  <= shift_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      nz_q     <= nz_d;
    end
  end

  // Results are loaded on the edge that accepts the last bit, so they are
  // already stable during the DONE cycle in which out_valid is raised.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cpl_r_d  = cpl_r_q;
    sign_r_d = sign_r_q;
    shift_d  = shift_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    nz_d     = nz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cpl_r_d = bus.cpl;
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        if (bus.bit_valid) begin
          sign_r_d = bus.bit_in;
          cnt_d    = CW'(WIDTH - 1);
          state_d  = S_MAG;
        end
      end
      S_MAG: begin
        if (bus.bit_valid) begin
          shift_d = {shift_q[WIDTH-3:0], dec_bit(bus.bit_in, sign_r_q, cpl_r_q)};
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            sign_d  = sign_r_q;
            mag_d   = shift_d;
            nz_d    = cpl_r_q & sign_r_q & (shift_d == '0);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready     = (state_q == S_IDLE);
    bus.busy      = (state_q == S_SIGN) || (state_q == S_MAG);
    bus.out_valid = (state_q == S_DONE);
    bus.sign      = sign_q;
    bus.mag       = mag_q;
    bus.neg_zero  = nz_q;
  end
endmodule

// File: tb/tb_compl1_serial_dec.sv
// Bench for compl1_serial_dec (WIDTH=4): vector table, corner sequences and
// randomized frames checked against a sign/magnitude reference model.
module tb_compl1_serial_dec;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   pulses = 0;

  compl1_serial_dec_if #(.WIDTH(WIDTH)) bus ();
  compl1_serial_dec #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.out_valid) pulses++;

  typedef struct {
    logic       cpl;
    logic [3:0] bits;
    int         gap;
    logic       s;
    logic [2:0] m;
    logic       nz;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int k = 0;
    while (bus.ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (bus.ready !== 1'b1) chk({nm, " ready timeout"}, 0, 1);
  endtask

  // Reference: sign is the MSB; magnitude inverted only when decoding a negative word.
  function automatic logic [2:0] ref_mag(input logic c, input logic [3:0] b);
    return (c && b[3]) ? ~b[2:0] : b[2:0];
  endfunction

  // Drives one frame starting at a negedge with the DUT idle; returns at the
  // negedge of the DONE cycle after checking outputs, then checks the pulse ends.
  task automatic run_frame(input logic c, input logic [3:0] b, input int gap,
                           input logic noisy, input string nm);
    int         p0;
    logic       es;
    logic [2:0] em;
    logic       enz;
    es  = b[3];
    em  = ref_mag(c, b);
    enz = c && b[3] && (em == 3'd0);
    wait_ready(nm);
    p0 = pulses;
    bus.start = 1'b1;
    bus.cpl = c;
    bus.bit_valid = noisy;
    bus.bit_in = ~b[3];
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) begin
        bus.bit_valid = 1'b0;
        bus.bit_in = 1'($urandom);
        if (noisy) begin
          bus.start = 1'($urandom);
          bus.cpl = 1'($urandom);
        end
        @(negedge clk);
      end
      bus.bit_valid = 1'b1;
      bus.bit_in = b[i];
      if (noisy) begin
        bus.start = 1'($urandom);
        bus.cpl = ~c;
      end
      @(negedge clk);
    end
    bus.bit_valid = 1'b0;
    bus.start = 1'b0;
    chk({nm, " out_valid"}, bus.out_valid, 1);
    chk({nm, " sign"}, bus.sign, es);
    chk({nm, " mag"}, bus.mag, em);
    chk({nm, " neg_zero"}, bus.neg_zero, enz);
    @(negedge clk);
    chk({nm, " pulse end"}, bus.out_valid, 0);
    chk({nm, " pulse count"}, pulses - p0, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cpl = 1'b0;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;

    tbl[0] = '{1'b1, 4'b1010, 0, 1'b1, 3'b101, 1'b0};
    tbl[1] = '{1'b1, 4'b0011, 0, 1'b0, 3'b011, 1'b0};
    tbl[2] = '{1'b1, 4'b0000, 0, 1'b0, 3'b000, 1'b0};
    tbl[3] = '{1'b1, 4'b1111, 0, 1'b1, 3'b000, 1'b1};
    tbl[4] = '{1'b0, 4'b1010, 1, 1'b1, 3'b010, 1'b0};
    tbl[5] = '{1'b1, 4'b1010, 3, 1'b1, 3'b101, 1'b0};

    #1;
    chk("reset ready", bus.ready, 1);
    chk("reset busy", bus.busy, 0);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset sign", bus.sign, 0);
    chk("reset mag", bus.mag, 0);
    chk("reset neg_zero", bus.neg_zero, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Table vectors: the expected columns are checked directly here.
    for (int v = 0; v < 6; v++) begin
      int p0;
      wait_ready($sformatf("vec%0d", v));
      p0 = pulses;
      bus.start = 1'b1;
      bus.cpl = tbl[v].cpl;
      @(negedge clk);
      bus.start = 1'b0;
      chk($sformatf("vec%0d busy", v), bus.busy, 1);
      for (int i = 3; i >= 0; i--) begin
        for (int g = 0; g < tbl[v].gap; g++) begin
          bus.bit_valid = 1'b0;
          bus.start = 1'b1;
          bus.cpl = ~tbl[v].cpl;
          @(negedge clk);
        end
        bus.bit_valid = 1'b1;
        bus.bit_in = tbl[v].bits[i];
        bus.cpl = ~tbl[v].cpl;
        @(negedge clk);
      end
      bus.bit_valid = 1'b0;
      bus.start = 1'b0;
      chk($sformatf("vec%0d out_valid", v), bus.out_valid, 1);
      chk($sformatf("vec%0d sign", v), bus.sign, tbl[v].s);
      chk($sformatf("vec%0d mag", v), bus.mag, tbl[v].m);
      chk($sformatf("vec%0d neg_zero", v), bus.neg_zero, tbl[v].nz);
      @(negedge clk);
      chk($sformatf("vec%0d pulse", v), pulses - p0, 1);
      @(negedge clk);
      chk($sformatf("vec%0d hold mag", v), bus.mag, tbl[v].m);
    end

    // start and bit_valid together in IDLE: that bit must not become the sign.
    run_frame(1'b1, 4'b1100, 0, 1'b1, "same-cycle start");

    // Reset after two accepted bits aborts the frame silently.
    begin
      int p0;
      run_frame(1'b0, 4'b1011, 0, 1'b0, "pre-reset");
      p0 = pulses;
      bus.start = 1'b1;
      bus.cpl = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.bit_valid = 1'b1;
      bus.bit_in = 1'b1;
      @(negedge clk);
      bus.bit_in = 1'b0;
      @(negedge clk);
      bus.bit_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("abort ready", bus.ready, 1);
      chk("abort busy", bus.busy, 0);
      chk("abort sign", bus.sign, 0);
      chk("abort mag", bus.mag, 0);
      chk("abort out_valid", bus.out_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort no pulse", pulses - p0, 0);
      run_frame(1'b1, 4'b1001, 0, 1'b0, "post-reset");
    end

    for (int r = 0; r < 40; r++) begin
      run_frame(1'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
                1'($urandom), $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
